// File: rtl/rt_mem_pkg.sv
// Shared types and constants for the racetrack memory controller.
package rt_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StAccess,
    StWait,
    StResp,
    StRealign
  } rt_ctrl_state_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // LiM function codes; zero selects a plain load/store.
  localparam logic [2:0] LIM_NONE  = 3'b000;
  localparam logic [2:0] LIM_AND   = 3'b001;
  localparam logic [2:0] LIM_RANGE = 3'b010;
  localparam logic [2:0] LIM_OR    = 3'b011;
  localparam logic [2:0] LIM_XOR   = 3'b100;

endpackage

// File: rtl/rt_shift_pulser.sv
// Emits n clk_m pulses (1 cycle high, 1 cycle low) with a fixed direction, then a done pulse
// coincident with the last low cycle.
module rt_shift_pulser #(
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] n_i,
  input  logic                 dir_i,
  output logic                 clk_m_o,
  output logic                 bz_s_o,
  output logic                 done_o
);

  logic                 busy_q, busy_d;
  logic                 phase_q, phase_d;
  logic                 dir_q, dir_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    done_o  = 1'b0;
    if (start_i && (n_i != '0)) begin
      busy_d  = 1'b1;
      phase_d = 1'b0;
      dir_d   = dir_i;
      rem_d   = n_i;
    end else if (busy_q) begin
      phase_d = ~phase_q;
      // Low phase closes one shift; the last one also ends the train.
      if (phase_q) begin
        rem_d = rem_q - CNT_WIDTH'(1);
        if (rem_q == CNT_WIDTH'(1)) begin
          done_o = 1'b1;
          busy_d = 1'b0;
        end
      end
    end
  end

  assign clk_m_o = busy_q & ~phase_q;
  assign bz_s_o  = busy_q & dir_q;

endmodule

// File: rtl/rt_mem_ctrl.sv
// Racetrack memory initiator sequencer: shift, access, wait, respond, realign.
// LiM mask/function passthrough is enabled by defining RT_MEM_CTRL_LIM_EN.
module rt_mem_ctrl
  import rt_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [DATA_WIDTH-1:0] data_mask_i,
  input  logic [2:0]            data_funct_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic                  en_ab_o,
  output logic [3:0]            be_b_o,
  output logic                  clk_m_o,
  output logic                  bz_s_o,
  output logic                  write_pulse_o,
  output logic                  read_pulse_o,
  output logic                  range_active_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  write_en_data_o,
  output logic [DATA_WIDTH-1:0] mask_o,
  output logic [2:0]            funct_o,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  input  logic                  r_valid_i
);

  localparam int unsigned WcntW = $clog2(TIMEOUT) + 1;

  rt_ctrl_state_e state_q, state_d;

  logic                  we_q;
  logic [3:0]            be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_WIDTH-1:0]  n_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [WcntW-1:0]      wcnt_q;

  logic                  gnt;
  logic                  capture;
  logic                  timeout;
  logic                  ps_start;
  logic [CNT_WIDTH-1:0]  ps_n;
  logic                  ps_dir;
  logic                  ps_done;

  assign gnt = data_req_i && (state_q == StIdle);

  rt_shift_pulser #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_pulser (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(ps_start),
    .n_i    (ps_n),
    .dir_i  (ps_dir),
    .clk_m_o(clk_m_o),
    .bz_s_o (bz_s_o),
    .done_o (ps_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      n_q     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        we_q    <= data_we_i;
        be_q    <= data_be_i;
        addr_q  <= data_addr_i;
        wdata_q <= data_wdata_i;
        n_q     <= data_addr_i[CNT_WIDTH-1:0];
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (capture) begin
        rdata_q <= r_data_i;
      end
      if (timeout) begin
        rdata_q <= DATA_WIDTH'(ERR_RDATA);
        err_q   <= 1'b1;
      end
      wcnt_q <= (state_q == StWait) ? wcnt_q + WcntW'(1) : '0;
    end
  end

  always_comb begin
    state_d         = state_q;
    ps_start        = 1'b0;
    ps_n            = n_q;
    ps_dir          = 1'b0;
    en_ab_o         = 1'b0;
    write_pulse_o   = 1'b0;
    read_pulse_o    = 1'b0;
    write_en_data_o = 1'b0;
    data_rvalid_o   = 1'b0;
    capture         = 1'b0;
    timeout         = 1'b0;
    case (state_q)
      StIdle: begin
        if (gnt) begin
          ps_start = 1'b1;
          ps_n     = data_addr_i[CNT_WIDTH-1:0];
          ps_dir   = 1'b1;
          state_d  = (data_addr_i[CNT_WIDTH-1:0] == '0) ? StAccess : StShift;
        end
      end
      StShift: begin
        if (ps_done) state_d = StAccess;
      end
      StAccess: begin
        en_ab_o         = 1'b1;
        write_pulse_o   = we_q;
        write_en_data_o = we_q;
        read_pulse_o    = ~we_q;
        if (we_q) begin
          state_d = StResp;
        end else if (r_valid_i) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        en_ab_o = 1'b1;
        // A valid in the final wait cycle still wins over the timeout.
        if (r_valid_i) begin
          capture = 1'b1;
          state_d = StResp;
        end else if (wcnt_q == WcntW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        data_rvalid_o = 1'b1;
        if (n_q == '0) begin
          state_d = StIdle;
        end else begin
          ps_start = 1'b1;
          ps_dir   = 1'b0;
          state_d  = StRealign;
        end
      end
      StRealign: begin
        if (ps_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign data_gnt_o   = gnt;
  assign data_rdata_o = data_rvalid_o ? rdata_q : '0;
  assign data_err_o   = data_rvalid_o & err_q;
  assign be_b_o       = be_q;
  assign addr_o       = addr_q;
  assign wdata_o      = wdata_q;

`ifdef RT_MEM_CTRL_LIM_EN
  logic [DATA_WIDTH-1:0] mask_q;
  logic [2:0]            funct_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q  <= '0;
      funct_q <= '0;
    end else if (gnt) begin
      mask_q  <= data_mask_i;
      funct_q <= data_funct_i;
    end
  end

  assign mask_o         = mask_q;
  assign funct_o        = funct_q;
  assign range_active_o = ((state_q == StAccess) || (state_q == StWait)) && (funct_q != LIM_NONE);
`else
  logic unused_lim;
  assign unused_lim     = ^{data_mask_i, data_funct_i};
  assign mask_o         = '0;
  assign funct_o        = '0;
  assign range_active_o = 1'b0;
`endif

endmodule

// File: tb/tb_rt_mem_ctrl.sv
// Directed bench for rt_mem_ctrl: vector table of single transactions plus reset/back-to-back cases.
module tb_rt_mem_ctrl;

`ifdef RT_MEM_CTRL_LIM_EN
  localparam bit LimEn = 1'b1;
`else
  localparam bit LimEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_gnt, data_we;
  logic [3:0]  data_be;
  logic [7:0]  data_addr;
  logic [31:0] data_wdata, data_mask;
  logic [2:0]  data_funct;
  logic        data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        en_ab, clk_m, bz_s, write_pulse, read_pulse, range_active, write_en_data;
  logic [3:0]  be_b;
  logic [7:0]  addr;
  logic [31:0] wdata, mask;
  logic [2:0]  funct;
  logic [31:0] r_data;
  logic        r_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rt_mem_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .data_req_i     (data_req),
    .data_gnt_o     (data_gnt),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_mask_i    (data_mask),
    .data_funct_i   (data_funct),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .en_ab_o        (en_ab),
    .be_b_o         (be_b),
    .clk_m_o        (clk_m),
    .bz_s_o         (bz_s),
    .write_pulse_o  (write_pulse),
    .read_pulse_o   (read_pulse),
    .range_active_o (range_active),
    .addr_o         (addr),
    .wdata_o        (wdata),
    .write_en_data_o(write_en_data),
    .mask_o         (mask),
    .funct_o        (funct),
    .r_data_i       (r_data),
    .r_valid_i      (r_valid)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic [2:0]  funct;
    int          rv_delay;    // cycles after read_pulse; -1 = never
    logic [31:0] rdata_in;
    int          exp_shifts;
    int          exp_rv_cycle; // cycle of rvalid, gnt cycle = 1
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_range;   // range_active cycles with LiM enabled
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_addr  = 8'h00;
    data_wdata = 32'h0;
    data_mask  = 32'h0;
    data_funct = 3'b000;
    r_valid    = 1'b0;
    r_data     = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulses"}, {en_ab, clk_m, bz_s, write_pulse, read_pulse, write_en_data,
                             data_rvalid, data_err, range_active}, 32'h0);
    check({tag, "_rdata"}, data_rdata, 32'h0);
    check({tag, "_addr"}, {24'h0, addr}, 32'h0);
    check({tag, "_wdata"}, wdata, 32'h0);
    check({tag, "_be"}, {28'h0, be_b}, 32'h0);
    check({tag, "_mask"}, mask, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int shifts = 0, realigns = 0, wp = 0, rp = 0, rv = 0, rv_cyc = 0, rng = 0, viol = 0;
    int since = -1;
    logic [31:0] rd = 32'h0;
    logic        er = 1'b0;
    logic        prev_clk = 1'b0, prev_wp = 1'b0, prev_rp = 1'b0;
    logic [31:0] acc_addr = 32'h0, acc_wdata = 32'h0, acc_be = 32'h0, acc_wed = 32'h0;
    logic [31:0] acc_mask = 32'h0, acc_funct = 32'h0;
    string p = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    data_req   = 1'b1;
    data_we    = v.we;
    data_addr  = v.addr;
    data_be    = v.be;
    data_wdata = v.wdata;
    data_mask  = v.mask;
    data_funct = v.funct;
    @(negedge clk);
    check({p, "_gnt"}, {31'h0, data_gnt}, 32'h1);
    @(posedge clk); #1;
    idle_inputs();
    for (int c = 2; c <= 50; c++) begin
      @(negedge clk);
      if (clk_m) begin
        if (bz_s) shifts++;
        else realigns++;
      end
      if (write_pulse || read_pulse) begin
        acc_addr  = {24'h0, addr};
        acc_wdata = wdata;
        acc_be    = {28'h0, be_b};
        acc_wed   = {31'h0, write_en_data};
        acc_mask  = mask;
        acc_funct = {29'h0, funct};
      end
      if (write_pulse) wp++;
      if (read_pulse) rp++;
      if (range_active) rng++;
      if (data_rvalid) begin
        rv++;
        rv_cyc = c;
        rd = data_rdata;
        er = data_err;
      end
      if (int'(clk_m) + int'(write_pulse) + int'(read_pulse) > 1) viol++;
      if ((clk_m && prev_clk) || (write_pulse && prev_wp) || (read_pulse && prev_rp)) viol++;
      prev_clk = clk_m;
      prev_wp  = write_pulse;
      prev_rp  = read_pulse;
      if (read_pulse) since = 0;
      else if (since >= 0) since++;
      if (v.rv_delay >= 0 && since == v.rv_delay) begin
        r_valid = 1'b1;
        r_data  = v.rdata_in;
      end else begin
        r_valid = 1'b0;
        r_data  = 32'h5555_AAAA;
      end
    end
    r_valid = 1'b0;
    check({p, "_shifts"}, shifts, v.exp_shifts);
    check({p, "_realigns"}, realigns, v.exp_shifts);
    check({p, "_wpulse"}, wp, v.we ? 1 : 0);
    check({p, "_rpulse"}, rp, v.we ? 0 : 1);
    check({p, "_rvalid_cnt"}, rv, 1);
    check({p, "_rvalid_cyc"}, rv_cyc, v.exp_rv_cycle);
    check({p, "_rdata"}, rd, v.exp_rdata);
    check({p, "_err"}, {31'h0, er}, {31'h0, v.exp_err});
    check({p, "_invariants"}, viol, 0);
    check({p, "_addr_o"}, acc_addr, {24'h0, v.addr});
    check({p, "_wdata_o"}, acc_wdata, v.wdata);
    check({p, "_be_o"}, acc_be, {28'h0, v.be});
    check({p, "_wen_data"}, acc_wed, {31'h0, v.we});
    check({p, "_mask_o"}, acc_mask, LimEn ? v.mask : 32'h0);
    check({p, "_funct_o"}, acc_funct, LimEn ? {29'h0, v.funct} : 32'h0);
    check({p, "_range"}, rng, LimEn ? v.exp_range : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gnt_idx[$];
    int viol;
    int rv;
    //          we    addr   be    wdata          mask           funct  dly rdata_in
    //          shifts rv_cyc exp_rdata      err  range
    vecs[0] = '{1'b1, 8'h05, 4'hF, 32'hA5A5_0001, 32'h0,         3'b000, -1, 32'h0,
                1, 5, 32'h0, 1'b0, 0};
    vecs[1] = '{1'b0, 8'h04, 4'hF, 32'h0,         32'h0,         3'b000, 2, 32'h1234_5678,
                0, 5, 32'h1234_5678, 1'b0, 0};
    vecs[2] = '{1'b0, 8'h07, 4'hF, 32'h0,         32'h0,         3'b000, -1, 32'h0,
                3, 25, 32'hDEAD_BEEF, 1'b1, 0};
    vecs[3] = '{1'b0, 8'h06, 4'h3, 32'h0,         32'h0,         3'b000, 0, 32'hCAFE_F00D,
                2, 7, 32'hCAFE_F00D, 1'b0, 0};
    vecs[4] = '{1'b1, 8'h03, 4'hC, 32'h0000_FFFF, 32'h0,         3'b000, -1, 32'h0,
                3, 9, 32'h0, 1'b0, 0};
    vecs[5] = '{1'b0, 8'h01, 4'hF, 32'h0,         32'h0,         3'b000, 16, 32'h0BAD_C0DE,
                1, 21, 32'h0BAD_C0DE, 1'b0, 0};
    vecs[6] = '{1'b0, 8'h04, 4'hF, 32'h0,         32'h0000_FFFF, 3'b010, 1, 32'h1357_9BDF,
                0, 4, 32'h1357_9BDF, 1'b0, 2};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    check("reset_gnt_noreq", {31'h0, data_gnt}, 32'h0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset during WAIT aborts with no response.
    @(posedge clk); #1;
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = 8'h04;
    data_be   = 4'hF;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_en_ab", {31'h0, en_ab}, 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_wait");
    r_valid = 1'b1;
    r_data  = 32'hFACE_0FF0;
    @(negedge clk);
    r_valid = 1'b0;
    rv = 0;
    for (int c = 0; c < 10; c++) begin
      if (data_rvalid) rv++;
      @(negedge clk);
    end
    check("rst_late_rvalid", rv, 0);
    data_req = 1'b1;
    #1;
    check("rst_idle_gnt", {31'h0, data_gnt}, 32'h1);
    data_req = 1'b0;

    // Back-to-back writes with request held: grants every 2n+3+2n = 7 cycles.
    @(posedge clk); #1;
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 8'h01;
    data_be    = 4'hF;
    data_wdata = 32'h0000_00B2;
    viol = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (data_gnt) gnt_idx.push_back(c);
      if (data_gnt && (en_ab || clk_m || data_rvalid)) viol++;
    end
    data_req = 1'b0;
    idle_inputs();
    check("b2b_gnt_count", gnt_idx.size(), 3);
    if (gnt_idx.size() == 3) begin
      check("b2b_gnt0", gnt_idx[0], 0);
      check("b2b_gnt1", gnt_idx[1], 7);
      check("b2b_gnt2", gnt_idx[2], 14);
    end
    check("b2b_overlap", viol, 0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
